// File: rtl/div_operand_feeder.sv
// ============================================================================
// div_operand_feeder : FIFO-buffered operand issue stage for the restoring divider
// Rev 1.0
// ============================================================================
`default_nettype none

module div_operand_feeder #(
  parameter int N     = 10,
  parameter int DEPTH = 2,
  parameter int TAGW  = 4
) (
  input  logic            clk,
  input  logic            sclr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_A,
  input  logic [N-1:0]    in_B,
  output logic [N-1:0]    inA,
  output logic [N-1:0]    inB,
  output logic            start,
  input  logic            div_done,
  output logic            busy,
  output logic            dz_err,
  output logic [TAGW-1:0] cur_tag
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2,
    S_DZ    = 2'd3
  } state_t;

  logic [N-1:0]    fifo_a_q [DEPTH];
  logic [N-1:0]    fifo_b_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  state_t          state_q, state_d;
  logic [N-1:0]    inA_q, inA_d, inB_q, inB_d;
  logic            start_q, start_d, busy_q, busy_d, dz_q, dz_d;
  logic [TAGW-1:0] cur_tag_q, cur_tag_d, tag_q, tag_d;
  logic            full, empty, push, pop;

  // in_ready depends on registered occupancy only, never on this cycle's pop
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = sclr & ~full;
  assign push     = in_valid & in_ready;

  always_comb begin
    state_d   = state_q;
    inA_d     = inA_q;
    inB_d     = inB_q;
    cur_tag_d = cur_tag_q;
    tag_d     = tag_q;
    start_d   = 1'b0;
    busy_d    = 1'b0;
    dz_d      = 1'b0;
    pop       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          inA_d     = fifo_a_q[rd_ptr_q];
          inB_d     = fifo_b_q[rd_ptr_q];
          cur_tag_d = tag_q;
          tag_d     = tag_q + TAGW'(1);
          if (~|fifo_b_q[rd_ptr_q]) begin
            state_d = S_DZ;
            dz_d    = 1'b1;
          end else begin
            state_d = S_ISSUE;
            start_d = 1'b1;
            busy_d  = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_BUSY;
        busy_d  = 1'b1;
      end
      S_BUSY: begin
        if (div_done) state_d = S_IDLE;
        else          busy_d  = 1'b1;
      end
      S_DZ:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!sclr) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      inA_q     <= '0;
      inB_q     <= '0;
      cur_tag_q <= '0;
      tag_q     <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      inA_q     <= inA_d;
      inB_q     <= inB_d;
      cur_tag_q <= cur_tag_d;
      tag_q     <= tag_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      dz_q      <= dz_d;
    end
  end

  // Storage needs no reset: occupancy is tracked solely by the pointers/count
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a_q[wr_ptr_q] <= in_A;
      fifo_b_q[wr_ptr_q] <= in_B;
    end
  end

  assign inA     = inA_q;
  assign inB     = inB_q;
  assign start   = start_q;
  assign busy    = busy_q;
  assign dz_err  = dz_q;
  assign cur_tag = cur_tag_q;

endmodule

`default_nettype wire
